// File: rtl/serial_argmax.sv
// rtl/serial_argmax.sv - framed streaming argmax with index, beat count and overflow flag
//
// Consumes signed samples framed by in_valid/in_ready/in_last and emits one
// result per frame: maximum value, 0-based index of its first occurrence,
// beat count minus one, and a sticky overflow flag for frames longer than
// 2**IDX_WIDTH beats.
//
// Optional feature macro: SERIAL_ARGMAX_MIN_EN
//   When defined, adds out_min / out_min_idx tracking the frame minimum.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid & in_ready
//   in_data      signed sample
//   in_last      final beat of frame
//   out_valid    result valid, held until out_ready
//   out_ready    result consumed when out_valid & out_ready
//   out_max      signed frame maximum
//   out_idx      index of first occurrence of the maximum
//   out_count    beats in frame minus 1 (saturating)
//   out_ovf      frame exceeded 2**IDX_WIDTH beats
//   out_min      signed frame minimum            (SERIAL_ARGMAX_MIN_EN)
//   out_min_idx  index of first occurrence of min (SERIAL_ARGMAX_MIN_EN)

module serial_argmax #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     out_max,
    output logic        [IDX_WIDTH-1:0] out_idx,
    output logic        [IDX_WIDTH-1:0] out_count,
    output logic                        out_ovf
`ifdef SERIAL_ARGMAX_MIN_EN
    ,
    output logic signed [WIDTH-1:0]     out_min,
    output logic        [IDX_WIDTH-1:0] out_min_idx
`endif
);

    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0]     acc_max, acc_max_nxt;
    logic        [IDX_WIDTH-1:0] acc_idx, acc_idx_nxt;
    logic        [IDX_WIDTH-1:0] cnt, cnt_nxt;
    logic                        ovf, ovf_nxt;
`ifdef SERIAL_ARGMAX_MIN_EN
    logic signed [WIDTH-1:0]     acc_min, acc_min_nxt;
    logic        [IDX_WIDTH-1:0] acc_min_idx, acc_min_idx_nxt;
`endif

    logic accept;
    logic emit;
    logic cnt_sat;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !in_last) state_nxt = ACCUM;
            ACCUM:   if (accept && in_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / handshake logic: a pending unconsumed result stalls all input.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        emit     = accept && in_last;
    end

    // Accumulator update. The emitted result is taken from these next values
    // so the last beat of the frame is included.
    always_comb begin
        acc_max_nxt = acc_max;
        acc_idx_nxt = acc_idx;
        cnt_nxt     = cnt;
        ovf_nxt     = ovf;
`ifdef SERIAL_ARGMAX_MIN_EN
        acc_min_nxt     = acc_min;
        acc_min_idx_nxt = acc_min_idx;
`endif
        cnt_sat = (cnt == IDX_MAX);
        if (accept) begin
            if (state == IDLE) begin
                acc_max_nxt = in_data;
                acc_idx_nxt = '0;
                cnt_nxt     = '0;
                ovf_nxt     = 1'b0;
`ifdef SERIAL_ARGMAX_MIN_EN
                acc_min_nxt     = in_data;
                acc_min_idx_nxt = '0;
`endif
            end else begin
                // Count saturates; beats past the limit mark the frame as
                // overflowed, and a new extreme found there takes the
                // saturated index.
                cnt_nxt = cnt_sat ? cnt : cnt + 1'b1;
                ovf_nxt = ovf || cnt_sat;
                if (in_data > acc_max) begin
                    acc_max_nxt = in_data;
                    acc_idx_nxt = cnt_nxt;
                end
`ifdef SERIAL_ARGMAX_MIN_EN
                if (in_data < acc_min) begin
                    acc_min_nxt     = in_data;
                    acc_min_idx_nxt = cnt_nxt;
                end
`endif
            end
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_max <= '0;
            acc_idx <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
`ifdef SERIAL_ARGMAX_MIN_EN
            acc_min     <= '0;
            acc_min_idx <= '0;
`endif
        end else begin
            acc_max <= acc_max_nxt;
            acc_idx <= acc_idx_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
`ifdef SERIAL_ARGMAX_MIN_EN
            acc_min     <= acc_min_nxt;
            acc_min_idx <= acc_min_idx_nxt;
`endif
        end
    end

    // Result registers: a new emit overrides a simultaneous consume, so
    // out_valid stays high with fresh data on back-to-back frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
`ifdef SERIAL_ARGMAX_MIN_EN
            out_min     <= '0;
            out_min_idx <= '0;
`endif
        end else begin
            if (emit) begin
                out_valid <= 1'b1;
                out_max   <= acc_max_nxt;
                out_idx   <= acc_idx_nxt;
                out_count <= cnt_nxt;
                out_ovf   <= ovf_nxt;
`ifdef SERIAL_ARGMAX_MIN_EN
                out_min     <= acc_min_nxt;
                out_min_idx <= acc_min_idx_nxt;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
